// File: rtl/pixel_stream_gen.sv
// pixel_stream_gen: streams a frame from pixel-addressed memory as ready/valid beats with hsync/vsync; define PIXEL_STREAM_BOTTOM_UP_EN for bottom-up (BMP) row order
module pixel_stream_gen #(
   parameter int CHANNELS  = 3,
   parameter int CHANNEL_W = 8,
   parameter int DIM_W     = 11,
   parameter int ADDR_W    = 20,
   parameter int H_BLANK   = 4,
   parameter int V_BLANK   = 16,
   localparam int PW       = CHANNELS * CHANNEL_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [DIM_W-1:0]  width,
   input  logic [DIM_W-1:0]  height,
   input  logic [ADDR_W-1:0] stride,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [PW-1:0]     mem_data,
   output logic [PW-1:0]     out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              hsync,
   output logic              vsync,
   output logic              busy,
   output logic              done
);
   typedef enum logic [2:0] {
      IDLE, VBLANK, ACTIVE, HBLANK, DRAIN
`ifdef PIXEL_STREAM_BOTTOM_UP_EN
      , PREP
`endif
   } state_t;
   state_t state, state_n, blank_entry, row_next;
   logic [ADDR_W-1:0] row_base, stride_q, row_step;
   logic [DIM_W-1:0] width_q, height_q, x, y;
   logic [31:0] cnt;
   logic [PW+1:0] b0, b1, in_beat, head;
   logic [1:0] occ, occ_n;
   logic inf_q, inf_hs, inf_vs, rd, last_x, last_y, pop, pop_buf, push, dims_zero, done_q;
   // read issue, skid-buffer head with fall-through of the returning read, occupancy bookkeeping
   always_comb begin
      dims_zero = width == '0 || height == '0;
      last_x = x == width_q - DIM_W'(1);
      last_y = y == height_q - DIM_W'(1);
      rd = state == ACTIVE && (occ + {1'b0, inf_q}) < 2'd2;
      in_beat = {inf_vs, inf_hs, mem_data};
      head = occ != 2'd0 ? b0 : inf_q ? in_beat : '0;
      out_valid = occ != 2'd0 || inf_q;
      pop = out_valid && out_ready;
      pop_buf = pop && occ != 2'd0;
      push = inf_q && !(occ == 2'd0 && pop);
      occ_n = occ + {1'b0, push} - {1'b0, pop_buf};
      blank_entry = V_BLANK == 0 ? ACTIVE : VBLANK;
      row_next = H_BLANK == 0 ? ACTIVE : HBLANK;
`ifdef PIXEL_STREAM_BOTTOM_UP_EN
      row_step = row_base - stride_q;
`else
      row_step = row_base + stride_q;
`endif
   end
   assign {vsync, hsync, out_data} = head;
   assign mem_rd = rd;
   assign mem_addr = rd ? row_base + ADDR_W'(x) : '0;
   assign busy = state != IDLE;
   assign done = done_q;
   // next-state: blanking counts run regardless of stalls, ACTIVE advances only on issued reads
   always_comb begin
      state_n = state;
      case (state)
`ifdef PIXEL_STREAM_BOTTOM_UP_EN
         IDLE:    if (start && !dims_zero) state_n = height != DIM_W'(1) ? PREP : blank_entry;
         PREP:    if (cnt == 32'(height_q) - 32'd2) state_n = blank_entry;
`else
         IDLE:    if (start && !dims_zero) state_n = blank_entry;
`endif
         VBLANK:  if (cnt == 32'(V_BLANK - 1)) state_n = ACTIVE;
         ACTIVE:  if (rd && last_x) state_n = last_y ? DRAIN : row_next;
         HBLANK:  if (cnt == 32'(H_BLANK - 1)) state_n = ACTIVE;
         DRAIN:   if (occ_n == 2'd0) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk) state <= reset ? IDLE : state_n;
   // per-state cycle counter, cleared on every state change
   always_ff @(posedge clk) cnt <= (reset || state_n != state) ? '0 : cnt + 32'd1;
   // frame parameters, position counters, in-flight read tags and the 2-entry skid buffer
   always_ff @(posedge clk) begin
      if (reset) begin
         done_q <= 1'b0;
         inf_q <= 1'b0;
         inf_hs <= 1'b0;
         inf_vs <= 1'b0;
         occ <= '0;
         b0 <= '0;
         b1 <= '0;
         width_q <= '0;
         height_q <= '0;
         stride_q <= '0;
         row_base <= '0;
         x <= '0;
         y <= '0;
      end else begin
         done_q <= (state == IDLE && start && dims_zero) || (state == DRAIN && state_n == IDLE);
         inf_q <= rd;
         inf_hs <= x == '0;
         inf_vs <= x == '0 && y == '0;
         occ <= occ_n;
         if (state == IDLE && start) begin
            width_q <= width;
            height_q <= height;
            stride_q <= stride;
            row_base <= base_addr;
            x <= '0;
            y <= '0;
         end
`ifdef PIXEL_STREAM_BOTTOM_UP_EN
         if (state == PREP) row_base <= row_base + stride_q;
`endif
         if (rd) begin
            x <= last_x ? '0 : x + DIM_W'(1);
            if (last_x) begin
               y <= y + DIM_W'(1);
               row_base <= row_step;
            end
         end
         if (push && (occ == 2'd0 || (occ == 2'd1 && pop_buf))) b0 <= in_beat;
         else if (occ == 2'd2 && pop_buf) b0 <= b1;
         if (push && ((occ == 2'd1 && !pop_buf) || (occ == 2'd2 && pop_buf))) b1 <= in_beat;
      end
   end
endmodule

// File: tb/tb_pixel_stream_gen.sv
// tb_pixel_stream_gen: table-driven and randomized frames checked against a row/column reference model
module tb_pixel_stream_gen;
   localparam int DIM_W = 11, ADDR_W = 20, PW = 24, H_BLANK = 4, V_BLANK = 16;
`ifdef PIXEL_STREAM_BOTTOM_UP_EN
   localparam bit BU = 1'b1;
`else
   localparam bit BU = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b1;
   logic [ADDR_W-1:0] base_addr = '0, stride = '0, mem_addr;
   logic [DIM_W-1:0] width = '0, height = '0;
   logic [PW-1:0] mem_data = '0, out_data;
   logic mem_rd, out_valid, hsync, vsync, busy, done;
   int n_chk = 0, n_fail = 0;

   typedef struct { int w, h, s, b, mode, mid, exp_beats, exp_first; } vec_t;
   vec_t vecs[9];

   pixel_stream_gen #(.H_BLANK(H_BLANK), .V_BLANK(V_BLANK)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .width(width),
      .height(height), .stride(stride), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_data(mem_data), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .hsync(hsync), .vsync(vsync), .busy(busy), .done(done));

   always #5 clk = ~clk;
   // memory holds its own address; unread cycles return junk
   always @(posedge clk) mem_data <= mem_rd ? PW'(mem_addr) : PW'($urandom);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_frame(input int w, input int h, input int s, input int b, input int mode,
                            input int mid, input int exp_beats, input int exp_first);
      logic [PW+1:0] eq[$];
      logic [ADDR_W-1:0] rq[$];
      logic [PW+1:0] prev, cur, e;
      logic [ADDR_W-1:0] a;
      bit stall;
      int acc, reads, first, last_acc, done_cnt, row;
      stall = 0; acc = 0; reads = 0; first = -1; last_acc = 0; done_cnt = 0; prev = '0;
      for (int r = 0; r < h; r++) begin
         row = BU ? h - 1 - r : r;
         for (int x = 0; x < w; x++) begin
            a = ADDR_W'(b + row * s + x);
            rq.push_back(a);
            eq.push_back({x == 0 && r == 0, x == 0, PW'(a)});
         end
      end
      @(posedge clk); #1;
      width = DIM_W'(w); height = DIM_W'(h); stride = ADDR_W'(s); base_addr = ADDR_W'(b);
      start = 1'b1;
      for (int c = 0; c < 600; c++) begin
         if (c > 0) start = mid != 0 && c == 20;
         if (c == 1) begin
            width = DIM_W'($urandom); height = DIM_W'($urandom);
            stride = ADDR_W'($urandom); base_addr = ADDR_W'($urandom);
         end
         out_ready = mode == 0 ? 1'b1 : mode == 1 ? (c % 4 == 0 || c % 4 == 3) : 1'($urandom_range(0, 1));
         @(negedge clk);
         if (mem_rd) begin
            chk("rd_outstanding", 64'(reads - acc < 2), 64'd1);
            if (rq.size() == 0) chk("rd_extra", 64'd1, 64'd0);
            else chk("rd_addr", 64'(mem_addr), 64'(rq.pop_front()));
            reads++;
         end
         cur = {vsync, hsync, out_data};
         if (stall) chk("stall_hold", {out_valid, cur}, {1'b1, prev});
         if (out_valid && out_ready) begin
            if (eq.size() == 0) chk("beat_extra", 64'd1, 64'd0);
            else begin
               e = eq.pop_front();
               chk("beat", 64'(cur), 64'(e));
               if (mode == 0 && acc > 0) chk("beat_gap", 64'(c - last_acc), 64'(acc % w == 0 ? H_BLANK + 1 : 1));
               if (first < 0) first = c;
               acc++;
               last_acc = c;
            end
         end
         stall = out_valid && !out_ready;
         prev = cur;
         if (done) begin
            chk("done_busy", 64'(busy), 64'd0);
            chk("done_after_last", 64'(c - last_acc), 64'd1);
            chk("done_beats", 64'(acc), 64'(exp_beats));
            done_cnt++;
            break;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk("done_seen", 64'(done_cnt), 64'd1);
      chk("beats_left", 64'(eq.size()), 64'd0);
      chk("reads_left", 64'(rq.size()), 64'd0);
      if (exp_first >= 0) chk("first_latency", 64'(first), 64'(exp_first + (BU ? h - 1 : 0)));
   endtask

   initial begin
      int acc, w, h;
      vecs = '{
         '{4, 2, 4, 'h10, 0, 0, 8, 18},
         '{4, 3, 6, 0, 0, 0, 12, 18},
         '{8, 2, 8, 'h40, 1, 0, 16, -1},
         '{0, 3, 4, 0, 0, 0, 0, -1},
         '{5, 0, 5, 0, 0, 0, 0, -1},
         '{4, 2, 4, 'h100, 0, 1, 8, 18},
         '{2, 3, 2, 0, 0, 0, 6, 18},
         '{3, 1, 3, 'hFFFFE, 0, 0, 3, 18},
         '{6, 3, 7, 'h20, 2, 0, 18, -1}};
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {mem_rd, mem_addr, out_valid, out_data, hsync, vsync, busy, done}, '0);
      @(posedge clk); #1;
      reset = 1'b0;
      foreach (vecs[i])
         run_frame(vecs[i].w, vecs[i].h, vecs[i].s, vecs[i].b, vecs[i].mode, vecs[i].mid,
                   vecs[i].exp_beats, vecs[i].exp_first);
      for (int k = 0; k < 5; k++) begin
         w = $urandom_range(1, 6);
         h = $urandom_range(1, 3);
         run_frame(w, h, w + $urandom_range(0, 3), $urandom_range(0, 20'hFFFFF), 2, 0, w * h, -1);
      end
      @(posedge clk); #1;
      width = 4; height = 2; stride = 4; base_addr = 'h200; out_ready = 1'b1; start = 1'b1;
      acc = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (out_valid && out_ready) acc++;
         if (acc == 7) break;
         @(posedge clk); #1;
         start = 1'b0;
      end
      start = 1'b0;
      chk("rst_reached", 64'(acc), 64'd7);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_clear", {mem_rd, mem_addr, out_valid, out_data, hsync, vsync, busy, done}, '0);
      reset = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("rst_quiet", {mem_rd, out_valid, busy, done}, '0);
      end
      run_frame(4, 2, 4, 'h10, 0, 0, 8, 18);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pixel_stream_gen.md
Name: pixel_stream_gen

Overview:
- Synthesizable frame source: reads pixels from a pixel-addressed frame memory and emits them as a ready/valid pixel stream with hsync/vsync markers.
- Feeds `top` in place of bench-driven stimulus, so that hardware and simulation share one stimulus path.
- Generalised in frame size, channel count/width, row stride and blanking, and adds backpressure.

Parameters:
- CHANNELS, 3, colour channels per pixel
- CHANNEL_W, 8, bits per channel; pixel width PW = CHANNELS*CHANNEL_W (24 = `PIXEL_SIZE)
- DIM_W, 11, width of the frame-dimension inputs
- ADDR_W, 20, memory address width (pixel granularity)
- H_BLANK, 4, idle cycles after each row (0 allowed)
- V_BLANK, 16, idle cycles before the first row (0 allowed)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a frame when idle
- base_addr  in  ADDR_W  address of the first-stored row, pixel 0
- width  in  DIM_W  pixels per row
- height  in  DIM_W  rows per frame
- stride  in  ADDR_W  address step between stored rows (≥ width; covers padding)
- mem_rd  out  1  read strobe
- mem_addr  out  ADDR_W  read address
- mem_data  in  PW  read data, valid exactly 1 cycle after mem_rd
- out_data  out  PW  pixel
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when out_valid&&out_ready
- hsync  out  1  qualifies beat: first pixel of a row
- vsync  out  1  qualifies beat: first pixel of the frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset (synchronous): state IDLE; all outputs 0; skid buffer empty; counters 0. Reset mid-frame abandons the frame: no done, and pending reads are discarded.
- width/height/stride/base_addr are sampled on accepted start and held internally; later input changes do not affect the frame.
- States:
  - IDLE: start → VBLANK. busy=0.
  - PREP: exists only with the optional feature; see below.
  - VBLANK: count V_BLANK cycles → ACTIVE.
  - ACTIVE: issue reads for x=0..width-1 at row_base+x. After the last read: if the last row → DRAIN, else → HBLANK.
  - HBLANK: count H_BLANK cycles; row_base += stride (incremental, no multiplier) → ACTIVE.
  - DRAIN: wait for the skid buffer to empty → IDLE with done=1 for 1 cycle.
- busy=1 in every state except IDLE; done and busy=0 coincide on the same cycle.
- start while busy is ignored. start with width==0 or height==0: done pulses on the next cycle, zero beats emitted, no mem_rd.
- Read pipeline: mem_rd=1 only when the 2-entry skid buffer has a free slot, counting reads in flight. Returned data enters the skid buffer. The output is the head of the skid buffer.
  - Throughput is 1 pixel/cycle with out_ready held high.
  - First beat of the frame appears V_BLANK+2 cycles after start: 1 cycle to enter VBLANK, V_BLANK cycles, 1 cycle read latency.
- Backpressure: while out_valid&&!out_ready, out_data/hsync/vsync/out_valid hold stable. Reads stop once the buffer plus in-flight reads reach 2; no pixel is lost or duplicated.
- hsync/vsync travel in the skid buffer with their pixel. hsync=1 on beat x==0 of every row; vsync=1 only on beat (x=0, first emitted row).
- Blanking inserts no beats: out_valid=0 once the buffer is drained. Counters freeze during stall only in ACTIVE; blanking counts proceed regardless.
- Arithmetic: addresses are modulo 2^ADDR_W (wrap, no error). Column/row counters are DIM_W bits; the last-element compare is against width-1/height-1.

Optional Feature:
- Macro: PIXEL_STREAM_BOTTOM_UP_EN (BMP row order).
- Defined:
  - Rows are emitted last-stored first.
  - From start, state PREP computes row_base = base_addr + (height-1)*stride by height-1 iterative additions (height-1 cycles), then enters VBLANK.
  - HBLANK subtracts stride instead of adding it.
  - First-beat latency grows by height-1 cycles.
- Undefined: PREP state and subtract path absent; rows emitted in storage order.

Test Plan:
- width=4, height=2, stride=4, base=0x10, H_BLANK=4, V_BLANK=16, out_ready=1, mem[a]=a → beats 0x10..0x13, 4 idle cycles, then 0x14..0x17. hsync on 0x10/0x14, vsync only on 0x10, first beat at cycle 18 after start, done 1 cycle after the 0x17 accept.
- stride=6, width=4, height=3, base=0 → addresses 0-3, 6-9, 12-15; padding addresses 4,5,10,11 are never read.
- out_ready toggles 1,0,0,1 repeating over an 8×2 frame → 16 beats in order, payload stable across every stall, no skid overflow (at most 2 outstanding), no mem_rd while 2 are pending.
- width=0 start → done next cycle, zero beats. start pulsed mid-frame → ignored, frame output unchanged.
- reset asserted on the 3rd beat of row 1 → next cycle all outputs 0 and state IDLE, no done. A new start produces a full correct frame.
- With PIXEL_STREAM_BOTTOM_UP_EN, width=2, height=3, stride=2, base=0 → address order 4,5,2,3,0,1. First beat at V_BLANK+4 cycles after start.
